// File: rtl/nios_led_pkg.sv
// Shared definitions for the Avalon-MM LED blinker: FSM encoding, register map, reset values.
package nios_led_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        STEADY    = 2'd1,
        BLINK_ON  = 2'd2,
        BLINK_OFF = 2'd3
    } led_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned PERIOD_RST = 500;
    localparam logic [7:0]  DUTY_RST   = 8'd255;

    // Lit phase: the LED is being driven (subject to PWM) in these states.
    function automatic logic phase_of(input led_state_e s);
        return (s == STEADY) || (s == BLINK_ON);
    endfunction

endpackage

// File: rtl/nios_led_tick_gen.sv
// Prescaler plus half-period counter; expire pulses for one cycle every max(period,1) prescaler ticks.
module nios_led_tick_gen #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    localparam int unsigned     PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PERIOD_W-1:0] half_last;
    logic                tick;

    always_comb begin
        half_last = (period == '0) ? '0 : period - PERIOD_W'(1);
        tick      = (presc_q == PS_LAST);
        presc_d   = presc_q;
        half_d    = half_q;
        expire    = 1'b0;
        // clr wins over a coincident expiry so a PERIOD write restarts the phase cleanly
        if (clr) begin
            presc_d = '0;
            half_d  = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PS_W'(1);
            if (tick) begin
                if (half_q == half_last) begin
                    half_d = '0;
                    expire = 1'b1;
                end else begin
                    half_d = half_q + PERIOD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            half_q  <= '0;
        end else begin
            presc_q <= presc_d;
            half_q  <= half_d;
        end
    end

endmodule

// File: rtl/nios_led_blinker.sv
// Avalon-MM controlled LED driver with steady/blink modes and optional PWM dimming.
// Define NIOS_LED_BLINKER_PWM_EN to build the DUTY register and PWM counter.
module nios_led_blinker #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        led_req,
    output logic        led_out
);

    import nios_led_pkg::*;

    led_state_e          state_q, state_d;
    logic                en_q, en_d, blink_q, blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                led_out_q, led_out_d;
    logic                wr_en, period_wr, active, clr, expire;
    logic                pwm_on, phase, unused_wdata;
    logic [31:0]         duty_rd;

    always_comb begin
        wr_en        = chipselect & ~write_n;
        period_wr    = wr_en && (address == ADDR_PERIOD);
        active       = en_q & led_req;
        unused_wdata = ^writedata;
        en_d         = en_q;
        blink_d      = blink_q;
        period_d     = period_q;
        if (wr_en && (address == ADDR_CTRL)) begin
            en_d    = writedata[0];
            blink_d = writedata[1];
        end
        if (period_wr) begin
            period_d = writedata[PERIOD_W-1:0];
        end
        // Counters are held clear outside blinking so every BLINK_ON entry starts a full phase
        clr = period_wr | ~((state_q == BLINK_ON) || (state_q == BLINK_OFF));
    end

    nios_led_tick_gen #(
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .period (period_q),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF, STEADY: state_d = blink_q ? BLINK_ON : STEADY;
                BLINK_ON:    state_d = !blink_q ? STEADY : (expire ? BLINK_OFF : BLINK_ON);
                BLINK_OFF:   state_d = !blink_q ? STEADY : (expire ? BLINK_ON : BLINK_OFF);
                default:     state_d = OFF;
            endcase
        end
        phase     = phase_of(state_q);
        led_out_d = phase & pwm_on;
    end

`ifdef NIOS_LED_BLINKER_PWM_EN
    logic [7:0] duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        duty_d = duty_q;
        if (wr_en && (address == ADDR_DUTY)) begin
            duty_d = writedata[7:0];
        end
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_on    = (pwm_cnt_q < duty_q);
        duty_rd   = {24'b0, duty_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= DUTY_RST;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    always_comb begin
        pwm_on  = 1'b1;
        duty_rd = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OFF;
            en_q      <= 1'b0;
            blink_q   <= 1'b0;
            period_q  <= PERIOD_W'(PERIOD_RST);
            led_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            blink_q   <= blink_d;
            period_q  <= period_d;
            led_out_q <= led_out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {30'b0, blink_q, en_q};
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
            ADDR_DUTY:   readdata = duty_rd;
            default:     readdata = {29'b0, phase, active, led_out_q};
        endcase
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_nios_led_blinker.sv
// Self-checking bench for nios_led_blinker (PRESCALE=4); expected phase/LED sequences are queued then drained.
module tb_nios_led_blinker;

`ifdef NIOS_LED_BLINKER_PWM_EN
    localparam int PWM = 1;
`else
    localparam int PWM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd3;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        led_req = 1'b0;
    logic        led_out;

    int total = 0;
    int bad = 0;
    bit exp_phase_q[$];
    bit exp_led_q[$];

    nios_led_blinker #(.PRESCALE(4), .PERIOD_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_req    (led_req),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write commits on the following rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd3;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
        address = 2'd3;
    endtask

    task automatic push_raw(input bit ph, input bit led);
        exp_phase_q.push_back(ph);
        exp_led_q.push_back(led);
    endtask

    // n0 samples of v0, then nh half-periods of length half alternating from ~v0.
    // The LED is the phase delayed by one cycle; led0 is its value at the first sample.
    task automatic push_seq(input bit v0, input int n0, input int half, input int nh, input bit led0);
        bit ph[$];
        bit v;
        for (int i = 0; i < n0; i++) ph.push_back(v0);
        v = ~v0;
        for (int h = 0; h < nh; h++) begin
            for (int i = 0; i < half; i++) ph.push_back(v);
            v = ~v;
        end
        exp_led_q.push_back(led0);
        for (int i = 0; i < ph.size(); i++) begin
            exp_phase_q.push_back(ph[i]);
            if (i < ph.size() - 1) exp_led_q.push_back(ph[i]);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_phase_q.size() > 0) begin
            bit ep;
            bit el;
            ep = exp_phase_q.pop_front();
            el = exp_led_q.pop_front();
            address = 2'd3;
            #1;
            chk({tag, ".phase"}, 32'(readdata[2]), 32'(ep));
`ifndef NIOS_LED_BLINKER_PWM_EN
            chk({tag, ".led"}, 32'(led_out), 32'(el));
`endif
            @(negedge clk);
        end
    endtask

    task automatic led_window(input string tag, input int exp_hi);
        int hi = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (led_out) hi++;
            @(negedge clk);
        end
        chk(tag, hi, exp_hi);
    endtask

    initial begin
        led_req = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst.led", 32'(led_out), 32'd0);
        rd_chk("rst.ctrl", 2'd0, 32'd0);
        rd_chk("rst.period", 2'd1, 32'd500);
        rd_chk("rst.duty", 2'd2, PWM ? 32'd255 : 32'd0);
        rd_chk("rst.status", 2'd3, 32'd0);
        @(negedge clk);

        // Steady on: LED follows two cycles after the enable takes effect
        wr(2'd0, 32'd1);
        push_seq(1'b0, 1, 20, 1, 1'b0);
        drain("steady");
        address = 2'd3;
        #1;
        chk("steady.ph_act", 32'(readdata[2:1]), 32'd3);
        @(negedge clk);
        led_window("duty255", PWM ? 255 : 256);

        // Disable: OFF the cycle after EN drops, LED one cycle later
        wr(2'd0, 32'd0);
        push_raw(1'b1, 1'b1);
        push_raw(1'b0, 1'b1);
        push_raw(1'b0, 1'b0);
        drain("en_off");

        // PERIOD=3 x PRESCALE=4 -> 12-cycle phases
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        push_seq(1'b0, 1, 12, 4, 1'b0);
        drain("blink");

        // PERIOD=0 while blinking: counters restart, phase toggles every tick
        wr(2'd1, 32'd0);
        push_seq(1'b1, 4, 4, 4, 1'b1);
        drain("per0");

        // Back to 12-cycle phases, then drop led_req mid BLINK_ON
        wr(2'd1, 32'd3);
        push_seq(1'b0, 12, 6, 1, 1'b0);
        drain("pre_drop");
        led_req = 1'b0;
        push_raw(1'b1, 1'b1);
        push_raw(1'b0, 1'b1);
        push_raw(1'b0, 1'b0);
        push_raw(1'b0, 1'b0);
        drain("drop");
        led_req = 1'b1;
        push_seq(1'b0, 1, 12, 2, 1'b0);
        drain("restart");

        // Dimming in steady mode
        wr(2'd0, 32'd1);
        wr(2'd2, 32'd64);
        repeat (4) @(negedge clk);
        led_window("duty64", PWM ? 64 : 256);
        rd_chk("duty.rd", 2'd2, PWM ? 32'd64 : 32'd0);

        // Write decode: high data bits dropped, unselected and STATUS writes ignored
        wr(2'd1, 32'hABCD_0005);
        rd_chk("period.mask", 2'd1, 32'd5);
        address    = 2'd1;
        writedata  = 32'd9;
        write_n    = 1'b0;
        chipselect = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        rd_chk("cs0.period", 2'd1, 32'd5);
        wr(2'd3, 32'd0);
        rd_chk("st_wr.ctrl", 2'd0, 32'd1);
        @(negedge clk);

        // Reset during BLINK_OFF with PERIOD=7 (28-cycle phases)
        wr(2'd1, 32'd7);
        wr(2'd0, 32'd3);
        repeat (34) @(negedge clk);
        address = 2'd3;
        #1;
        chk("boff.phase", 32'(readdata[2]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2.led", 32'(led_out), 32'd0);
        rd_chk("rst2.ctrl", 2'd0, 32'd0);
        rd_chk("rst2.period", 2'd1, 32'd500);
        rd_chk("rst2.duty", 2'd2, PWM ? 32'd255 : 32'd0);
        rd_chk("rst2.status", 2'd3, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst2.led_hold", 32'(led_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_led_blinker.md
NIOS_LED_BLINKER -- requirements
Module: nios_led_blinker

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per blink tick (1 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter PERIOD_W, default 16, meaning width of the blink half-period register.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data; combinational, read latency 0.
REQ-010 SHALL have port led_req  input  1  LED request driven by the upstream 1-bit PIO output port.
REQ-011 SHALL have port led_out  output  1  registered drive to the board LED pin.

Function
REQ-012 SHALL decode register map: addr0 CTRL (bit0 EN, bit1 BLINK), addr1 PERIOD[PERIOD_W-1:0], addr2 DUTY[7:0], addr3 STATUS (read-only).
REQ-013 SHALL accept a write only when chipselect=1 and write_n=0; unused writedata bits are ignored; writes to addr3 have no effect.
REQ-014 SHALL return readdata zero-extended: CTRL {30'b0,BLINK,EN}, PERIOD, DUTY, STATUS {29'b0,phase,active,led_out}.
REQ-015 SHALL define active = EN & led_req, sampled every clk.
REQ-016 SHALL implement FSM states OFF, STEADY, BLINK_ON, BLINK_OFF.
REQ-017 SHALL transition from any state to OFF on the cycle after active=0; OFF->STEADY when active & ~BLINK; OFF->BLINK_ON when active & BLINK.
REQ-018 SHALL move STEADY<->BLINK_ON when BLINK is changed while active; BLINK_OFF->STEADY when BLINK cleared.
REQ-019 SHALL toggle BLINK_ON<->BLINK_OFF when the half-period counter expires: counter increments once per prescaler tick and expires at PERIOD-1.
REQ-020 SHALL treat PERIOD=0 as PERIOD=1 (toggle every tick).
REQ-021 SHALL clear prescaler and half-period counters on entry to OFF and on any PERIOD write; each BLINK_ON phase then lasts exactly PERIOD*PRESCALE cycles.
REQ-022 SHALL run a free-running 8-bit PWM counter; pwm_on = (pwm_cnt < DUTY); DUTY=0 gives off, DUTY=255 gives 255/256 on.
REQ-023 SHALL register led_out = (state in {STEADY,BLINK_ON}) & pwm_on; led_out lags led_req by exactly 2 clk cycles (FSM register + output register).
REQ-024 SHALL report STATUS.phase=1 in STEADY/BLINK_ON, 0 otherwise.
REQ-025 SHALL give a same-cycle register write and counter expiry priority to the write.

Reset
REQ-026 SHALL on reset=1 at a clk edge set: state OFF, CTRL=0, PERIOD=500, DUTY=255, all counters 0, led_out=0.
REQ-027 SHALL abort any blink in progress on reset mid-operation with led_out=0 the following cycle.

Configuration
REQ-028 SHALL, with macro NIOS_LED_BLINKER_PWM_EN defined, implement DUTY and the PWM counter as in REQ-022.
REQ-029 SHALL, without NIOS_LED_BLINKER_PWM_EN, omit the PWM counter and the DUTY register, force pwm_on=1, read addr2 as 0, and ignore writes to addr2.

Structure
REQ-030 SHALL place the state encoding typedef, register address constants and reset values (PERIOD=500, DUTY=255) in shared package nios_led_pkg.
REQ-031 SHALL implement the prescaler plus half-period counter as sub-module nios_led_tick_gen (inputs clr, period; output expire pulse).

Verification
REQ-032 SHALL cover: reset, CTRL=1, led_req=1, DUTY=255 -> led_out=1 from cycle 2 onward except 1 cycle in every 256 (PWM wrap).
REQ-033 SHALL cover: PRESCALE=4, PERIOD=3, CTRL=3, led_req=1 -> led_out alternates in 12-cycle on/off phases; STATUS.phase tracks it.
REQ-034 SHALL cover: PERIOD=0 with PRESCALE=4 while blinking -> phase toggles every 4 cycles.
REQ-035 SHALL cover: led_req dropped mid-BLINK_ON -> led_out=0 two cycles later; reasserting restarts a full BLINK_ON phase.
REQ-036 SHALL cover: DUTY=64, CTRL=1 -> exactly 64 high cycles per 256-cycle window; without NIOS_LED_BLINKER_PWM_EN, addr2 reads 0 and led_out stays 1.
REQ-037 SHALL cover: reset asserted during BLINK_OFF with PERIOD=7 written -> registers read back CTRL=0, PERIOD=500, DUTY=255.
